post_adder_acc: RTL and testbench



---
 rtl/post_adder_acc.sv | 134 +++++++++++++
 tb/tb_post_adder_acc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/post_adder_acc.sv
// rtl/post_adder_acc.sv - DSP post-adder / accumulator with P register, overflow and pattern detect
module post_adder_acc #(
  parameter bit          PREG    = 1'b1,
  parameter bit          CREG    = 1'b1,
  parameter bit          CTRLREG = 1'b1,
  parameter logic [47:0] PATTERN = 48'h0,
  parameter logic [47:0] MASK    = 48'h0
) (
  input  logic               CLK,
  input  logic               RSTP,
  input  logic               RSTC,
  input  logic               RSTCTRL,
  input  logic               CEP,
  input  logic               CEC,
  input  logic               CECTRL,
  input  logic signed [42:0] MULT_OUT,
  input  logic        [47:0] C,
  input  logic        [47:0] PCIN,
  input  logic        [3:0]  OPMODE,
  input  logic        [1:0]  ALUMODE,
  input  logic               CARRYIN,
  output logic        [47:0] P,
  output logic        [47:0] PCOUT,
  output logic               OVERFLOW,
  output logic               PATTERNDETECT
);

  logic [47:0]        c_q;
  logic [3:0]         opmode_q;
  logic [1:0]         alumode_q;
  logic               carryin_q;
  logic [47:0]        p_q;
  logic               overflow_q;
  logic               patdet_q;

  logic [47:0]        c_use;
  logic [3:0]         opmode_use;
  logic [1:0]         alumode_use;
  logic               carryin_use;
  logic [47:0]        m_ext;
  logic [47:0]        p_fb;
  logic [47:0]        x_mux;
  logic [47:0]        z_mux;
  logic signed [49:0] exact_d;
  logic [47:0]        res_d;
  logic               overflow_d;
  logic               patdet_d;

  // C operand register; reset only takes effect on clock-enabled cycles
  always_ff @(posedge CLK) begin
    if (CEC) begin
      if (RSTC) c_q <= '0;
      else      c_q <= C;
    end
  end

  // Control register group (OPMODE, ALUMODE, CARRYIN)
  always_ff @(posedge CLK) begin
    if (CECTRL) begin
      if (RSTCTRL) begin
        opmode_q  <= '0;
        alumode_q <= '0;
        carryin_q <= 1'b0;
      end else begin
        opmode_q  <= OPMODE;
        alumode_q <= ALUMODE;
        carryin_q <= CARRYIN;
      end
    end
  end

  assign c_use       = CREG    ? c_q       : C;
  assign opmode_use  = CTRLREG ? opmode_q  : OPMODE;
  assign alumode_use = CTRLREG ? alumode_q : ALUMODE;
  assign carryin_use = CTRLREG ? carryin_q : CARRYIN;

  assign m_ext = {{5{MULT_OUT[42]}}, MULT_OUT};
  // Without a P register the feedback path is tied off to avoid a combinational loop
  assign p_fb  = PREG ? p_q : 48'd0;

  // Operand muxes and the add/subtract with a 50-bit exact result for overflow
  always_comb begin
    x_mux      = '0;
    z_mux      = '0;
    exact_d    = '0;
    res_d      = '0;
    overflow_d = 1'b0;
    patdet_d   = 1'b0;
    case (opmode_use[1:0])
      2'b01:   x_mux = m_ext;
      2'b10:   x_mux = p_fb;
      2'b11:   x_mux = c_use;
      default: x_mux = '0;
    endcase
    case (opmode_use[3:2])
      2'b01:   z_mux = PCIN;
      2'b10:   z_mux = p_fb;
      2'b11:   z_mux = c_use;
      default: z_mux = '0;
    endcase
    if (alumode_use == 2'b11) begin
      exact_d = $signed({{2{z_mux[47]}}, z_mux}) - $signed({{2{x_mux[47]}}, x_mux})
              - $signed({49'd0, carryin_use});
    end else begin
      exact_d = $signed({{2{z_mux[47]}}, z_mux}) + $signed({{2{x_mux[47]}}, x_mux})
              + $signed({49'd0, carryin_use});
    end
    res_d      = exact_d[47:0];
    // The result fits in 48 signed bits only when the top three bits agree
    overflow_d = (exact_d[49:47] != {3{exact_d[47]}});
    patdet_d   = (((res_d ^ PATTERN) & ~MASK) == 48'd0);
  end

  // P group: result, overflow and pattern flag load together so they stay consistent
  always_ff @(posedge CLK) begin
    if (CEP) begin
      if (RSTP) begin
        p_q        <= '0;
        overflow_q <= 1'b0;
        patdet_q   <= 1'b0;
      end else begin
        p_q        <= res_d;
        overflow_q <= overflow_d;
        patdet_q   <= patdet_d;
      end
    end
  end

  assign P             = PREG ? p_q        : res_d;
  assign PCOUT         = P;
  assign OVERFLOW      = PREG ? overflow_q : overflow_d;
  assign PATTERNDETECT = PREG ? patdet_q   : patdet_d;

endmodule

// File: tb/tb_post_adder_acc.sv
// tb/tb_post_adder_acc.sv - self-checking bench for post_adder_acc
module tb_post_adder_acc;

  logic               CLK = 1'b0;
  logic               RSTP, RSTC, RSTCTRL, CEP, CEC, CECTRL;
  logic signed [42:0] MULT_OUT;
  logic [47:0]        C, PCIN;
  logic [3:0]         OPMODE;
  logic [1:0]         ALUMODE;
  logic               CARRYIN;

  logic [47:0] p_a, pc_a, p_b, pc_b, p_c, pc_c;
  logic        ov_a, pd_a, ov_b, pd_b, ov_c, pd_c;

  int total = 0;
  int bad   = 0;

  // reference state: previous-cycle C and control, plus P/flags
  logic [47:0] mc = '0;
  logic [3:0]  mop = '0;
  logic [1:0]  malu = '0;
  logic        mcin = 1'b0;
  logic [47:0] mp = '0;
  logic        mov = 1'b0, mpd_a = 1'b0, mpd_b = 1'b0;

  always #5 CLK = ~CLK;

  post_adder_acc #(.PREG(1'b1), .CREG(1'b1), .CTRLREG(1'b1), .PATTERN(48'h64), .MASK(48'h0)) u_a (
    .CLK(CLK), .RSTP(RSTP), .RSTC(RSTC), .RSTCTRL(RSTCTRL), .CEP(CEP), .CEC(CEC), .CECTRL(CECTRL),
    .MULT_OUT(MULT_OUT), .C(C), .PCIN(PCIN), .OPMODE(OPMODE), .ALUMODE(ALUMODE), .CARRYIN(CARRYIN),
    .P(p_a), .PCOUT(pc_a), .OVERFLOW(ov_a), .PATTERNDETECT(pd_a));

  post_adder_acc #(.PREG(1'b1), .CREG(1'b1), .CTRLREG(1'b1), .PATTERN(48'h64), .MASK(48'h3)) u_b (
    .CLK(CLK), .RSTP(RSTP), .RSTC(RSTC), .RSTCTRL(RSTCTRL), .CEP(CEP), .CEC(CEC), .CECTRL(CECTRL),
    .MULT_OUT(MULT_OUT), .C(C), .PCIN(PCIN), .OPMODE(OPMODE), .ALUMODE(ALUMODE), .CARRYIN(CARRYIN),
    .P(p_b), .PCOUT(pc_b), .OVERFLOW(ov_b), .PATTERNDETECT(pd_b));

  post_adder_acc #(.PREG(1'b0), .CREG(1'b0), .CTRLREG(1'b0), .PATTERN(48'h0), .MASK(48'h0)) u_c (
    .CLK(CLK), .RSTP(RSTP), .RSTC(RSTC), .RSTCTRL(RSTCTRL), .CEP(CEP), .CEC(CEC), .CECTRL(CECTRL),
    .MULT_OUT(MULT_OUT), .C(C), .PCIN(PCIN), .OPMODE(OPMODE), .ALUMODE(ALUMODE), .CARRYIN(CARRYIN),
    .P(p_c), .PCOUT(pc_c), .OVERFLOW(ov_c), .PATTERNDETECT(pd_c));

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] sext(input logic signed [42:0] m);
    longint v;
    v = m;
    return v[47:0];
  endfunction

  // {overflow, result} from the operation table using plain signed integer arithmetic
  function automatic logic [48:0] model(input logic [3:0] op, input logic [1:0] alu, input logic cin,
                                        input logic [47:0] c, input logic [47:0] m,
                                        input logic [47:0] pcin, input logic [47:0] pfb);
    logic [47:0] x, z;
    longint xs, zs, ex;
    logic ov;
    case (op[1:0])
      2'd0: x = 48'd0;
      2'd1: x = m;
      2'd2: x = pfb;
      default: x = c;
    endcase
    case (op[3:2])
      2'd0: z = 48'd0;
      2'd1: z = pcin;
      2'd2: z = pfb;
      default: z = c;
    endcase
    xs = $signed(x);
    zs = $signed(z);
    if (alu == 2'b11) ex = zs - xs - longint'(cin);
    else              ex = zs + xs + longint'(cin);
    ov = (ex > 64'sh0000_7FFF_FFFF_FFFF) || (ex < -64'sh0000_8000_0000_0000);
    return {ov, ex[47:0]};
  endfunction

  task automatic tick();
    logic [48:0] r;
    @(negedge CLK);
    r = model(OPMODE, ALUMODE, CARRYIN, C, sext(MULT_OUT), PCIN, 48'd0);
    check("comb_p", p_c, r[47:0]);
    check("comb_ov", {47'd0, ov_c}, {47'd0, r[48]});
    check("comb_pd", {47'd0, pd_c}, {47'd0, r[47:0] == 48'd0});
    @(posedge CLK);
    if (CEP) begin
      if (RSTP) begin
        mp = '0; mov = 1'b0; mpd_a = 1'b0; mpd_b = 1'b0;
      end else begin
        r = model(mop, malu, mcin, mc, sext(MULT_OUT), PCIN, mp);
        mp    = r[47:0];
        mov   = r[48];
        mpd_a = (mp == 48'd100);
        mpd_b = ((mp >> 2) == 48'd25);
      end
    end
    if (CEC) mc = RSTC ? 48'd0 : C;
    if (CECTRL) begin
      mop  = RSTCTRL ? 4'd0 : OPMODE;
      malu = RSTCTRL ? 2'd0 : ALUMODE;
      mcin = RSTCTRL ? 1'b0 : CARRYIN;
    end
    #1;
    check("reg_p", p_a, mp);
    check("reg_pcout", pc_a, mp);
    check("reg_ov", {47'd0, ov_a}, {47'd0, mov});
    check("reg_pd", {47'd0, pd_a}, {47'd0, mpd_a});
    check("reg_pd_masked", {47'd0, pd_b}, {47'd0, mpd_b});
  endtask

  initial begin
    logic [63:0] t;
    logic [47:0] held;
    RSTP = 1'b1; RSTC = 1'b1; RSTCTRL = 1'b1; CEP = 1'b1; CEC = 1'b1; CECTRL = 1'b1;
    MULT_OUT = '0; C = '0; PCIN = '0; OPMODE = '0; ALUMODE = '0; CARRYIN = 1'b0;
    tick(); tick();
    check("reset_p", p_a, 48'd0);
    check("reset_pcout", pc_a, 48'd0);
    check("reset_ov", {47'd0, ov_a}, 48'd0);
    check("reset_pd", {47'd0, pd_a}, 48'd0);
    RSTP = 1'b0; RSTC = 1'b0; RSTCTRL = 1'b0;

    // random P, then RSTP with and without CEP
    t = {$urandom, $urandom};
    OPMODE = 4'b0011; C = t[47:0];
    tick(); tick();
    check("load_rand", p_a, t[47:0]);
    RSTP = 1'b1;
    tick();
    check("rstp_p", p_a, 48'd0);
    check("rstp_ov", {47'd0, ov_a}, 48'd0);
    check("rstp_pd", {47'd0, pd_a}, 48'd0);
    RSTP = 1'b0;
    tick();
    held = t[47:0];
    RSTP = 1'b1; CEP = 1'b0;
    tick();
    check("rstp_no_cep", p_a, held);
    RSTP = 1'b0; CEP = 1'b1;

    // single pass of M = -5
    OPMODE = 4'b0001; ALUMODE = 2'b00; CARRYIN = 1'b0; MULT_OUT = -43'sd5;
    tick(); tick();
    check("single_pass", p_a, 48'hFFFF_FFFF_FFFB);
    check("single_ov", {47'd0, ov_a}, 48'd0);

    // accumulate 3 per enabled cycle
    OPMODE = 4'b1001; MULT_OUT = 43'sd0; RSTP = 1'b1;
    tick();
    RSTP = 1'b0; MULT_OUT = 43'sd3;
    tick(); check("acc_3", p_a, 48'd3);
    tick(); check("acc_6", p_a, 48'd6);
    tick(); check("acc_9", p_a, 48'd9);
    tick(); check("acc_12", p_a, 48'd12);
    CEP = 1'b0;
    tick(); tick();
    check("acc_hold", p_a, 48'd12);
    CEP = 1'b1; RSTP = 1'b1;
    tick(); check("acc_rst", p_a, 48'd0);
    RSTP = 1'b0;
    tick(); check("acc_resume", p_a, 48'd3);

    // subtract with registered C: 100 - (30 + 1)
    C = 48'd100; MULT_OUT = 43'sd30; CARRYIN = 1'b1; ALUMODE = 2'b11; OPMODE = 4'b1101;
    tick(); tick();
    check("sub_c", p_a, 48'd69);

    // overflow from max positive + 1
    OPMODE = 4'b0011; ALUMODE = 2'b00; CARRYIN = 1'b0; C = 48'h7FFF_FFFF_FFFF;
    tick(); tick();
    check("ovf_pre", p_a, 48'h7FFF_FFFF_FFFF);
    OPMODE = 4'b1001; MULT_OUT = 43'sd1;
    tick(); tick();
    check("ovf_p", p_a, 48'h8000_0000_0000);
    check("ovf_flag", {47'd0, ov_a}, 48'd1);

    // pattern detect while accumulating 25
    MULT_OUT = 43'sd0; RSTP = 1'b1;
    tick();
    RSTP = 1'b0; MULT_OUT = 43'sd25;
    tick(); check("pd_25", {47'd0, pd_a}, 48'd0);
    tick(); check("pd_50", {47'd0, pd_a}, 48'd0);
    tick(); check("pd_75", {47'd0, pd_a}, 48'd0);
    tick(); check("pd_100", {47'd0, pd_a}, 48'd1);
    check("pd_100_masked", {47'd0, pd_b}, 48'd1);
    tick(); check("pd_125", {47'd0, pd_a}, 48'd0);
    OPMODE = 4'b0011; C = 48'd101;
    tick(); tick();
    check("pd_101", {47'd0, pd_a}, 48'd0);
    check("pd_101_masked", {47'd0, pd_b}, 48'd1);

    // randomized operation against the reference
    for (int i = 0; i < 300; i++) begin
      t = {$urandom, $urandom}; C = t[47:0];
      t = {$urandom, $urandom}; PCIN = t[47:0];
      t = {$urandom, $urandom};
      MULT_OUT = ($urandom_range(0, 3) == 0) ? 43'sd25 : t[42:0];
      OPMODE   = 4'($urandom);
      ALUMODE  = 2'($urandom);
      CARRYIN  = 1'($urandom);
      CEP      = ($urandom_range(0, 7) != 0);
      CEC      = ($urandom_range(0, 7) != 0);
      CECTRL   = ($urandom_range(0, 7) != 0);
      RSTP     = ($urandom_range(0, 15) == 0);
      RSTC     = ($urandom_range(0, 15) == 0);
      RSTCTRL  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
